// File: rtl/par_frame_check.sv
// rtl/par_frame_check.sv - multi-lane serial frame parity checker with saturating error counters
module par_frame_check #(
  parameter int NUM_CH    = 4,
  parameter int FRAME_LEN = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             i_in_valid,
  input  logic [NUM_CH-1:0]             i_sr_in,
  input  logic                          i_odd_mode,
  input  logic                          i_sync,
  input  logic                          i_err_clr,
  output logic [NUM_CH-1:0]             o_par_out,
  output logic [NUM_CH-1:0]             o_in_check,
  output logic [NUM_CH-1:0]             o_frame_done,
  output logic [NUM_CH-1:0]             o_par_err,
  output logic [NUM_CH*ERR_CNT_W-1:0]   o_err_cnt
);

  // Bit counter only needs to reach FRAME_LEN-1; keep at least one bit for FRAME_LEN=1.
  localparam int                   CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(FRAME_LEN - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

  typedef enum logic {
    S_DATA  = 1'b0,
    S_CHECK = 1'b1
  } state_t;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_lane
      state_t                 r_state;
      logic [CNT_W-1:0]       r_cnt;
      logic                   r_par;
      logic                   r_done;
      logic                   r_err;
      logic [ERR_CNT_W-1:0]   r_err_cnt;
      logic                   w_accept;
      logic                   w_mismatch;

      // sync discards any bit presented in the same cycle, so it blocks acceptance outright.
      assign w_accept   = i_in_valid[g] & ~i_sync;
      // odd_mode is only looked at here, when the parity bit itself is accepted.
      assign w_mismatch = w_accept & (r_state == S_CHECK) &
                          ((r_par ^ i_sr_in[g]) != i_odd_mode);

      // Lane FSM: data bits accumulate parity, the bit after the last data bit is the check bit.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_state <= S_DATA;
          r_cnt   <= '0;
          r_par   <= 1'b0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end else begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (i_sync) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
            r_par   <= 1'b0;
          end else if (i_in_valid[g]) begin
            case (r_state)
              S_DATA: begin
                r_par <= r_par ^ i_sr_in[g];
                if (r_cnt == LAST_BIT) begin
                  r_cnt   <= '0;
                  r_state <= S_CHECK;
                end else begin
                  r_cnt <= r_cnt + 1'b1;
                end
              end
              S_CHECK: begin
                r_done  <= 1'b1;
                r_err   <= w_mismatch;
                r_par   <= 1'b0;
                r_cnt   <= '0;
                r_state <= S_DATA;
              end
              default: begin
                r_state <= S_DATA;
                r_cnt   <= '0;
                r_par   <= 1'b0;
              end
            endcase
          end
        end
      end

      // Saturating error counter; a coincident clear beats the increment.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_err_cnt <= '0;
        end else if (i_err_clr) begin
          r_err_cnt <= '0;
        end else if (w_mismatch && (r_err_cnt != ERR_MAX)) begin
          r_err_cnt <= r_err_cnt + 1'b1;
        end
      end

      assign o_par_out[g]                         = r_par;
      assign o_in_check[g]                        = (r_state == S_CHECK);
      assign o_frame_done[g]                      = r_done;
      assign o_par_err[g]                         = r_err;
      assign o_err_cnt[g*ERR_CNT_W +: ERR_CNT_W]  = r_err_cnt;
    end
  endgenerate

endmodule
